// File: rtl/camera_source.sv
// camera_source: cycle-accurate camera sensor emulator producing blanked frames of test patterns.
// Define CAM_SRC_PRBS_EN to turn pattern 3 into an 8-bit PRBS instead of frame_count[7:0].
module camera_source #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 8,
  parameter int HBLANK = 4,
  parameter int VBLANK = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic        cam_valid,
  output logic        cam_sof,
  output logic        cam_eol,
  output logic [7:0]  cam_pixel,
  output logic [15:0] frame_count,
  output logic        busy
);

  // A one-pixel-wide or one-line-tall frame still needs a 1-bit counter.
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
  localparam logic [XW-1:0] X_ONE   = XW'(1);
  localparam logic [YW-1:0] Y_ONE   = YW'(1);
  localparam logic [15:0]   HB_LAST = 16'(HBLANK - 1);
  localparam logic [15:0]   VB_LAST = 16'(VBLANK - 1);
  localparam bit            HB_NONE = (HBLANK == 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  state_t        state_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [15:0]   bcnt_r;
  logic [1:0]    pat_r;
  logic [15:0]   frame_count_r;
  logic          valid_r;
  logic          sof_r;
  logic          eol_r;
  logic [7:0]    pixel_r;
  logic          busy_r;
  logic [7:0]    pixel_s;
  logic          start_s;

`ifdef CAM_SRC_PRBS_EN
  logic [7:0]    lfsr_r;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
`endif

  // Pixel value for the current (x,y) under the pattern latched at frame start.
  always_comb begin
    pixel_s = 8'h00;
    case (pat_r)
      2'd0: pixel_s = 8'(x_r) + 8'(y_r);
      2'd1: pixel_s = 8'h80;
      2'd2: pixel_s = (x_r[0] ^ y_r[0]) ? 8'hFF : 8'h00;
      2'd3: begin
`ifdef CAM_SRC_PRBS_EN
        pixel_s = lfsr_r;
`else
        pixel_s = frame_count_r[7:0];
`endif
      end
      default: pixel_s = 8'h00;
    endcase
  end

  // A new frame may only begin from idle or on the final vertical blanking cycle.
  always_comb begin
    start_s = 1'b0;
    if (enable && ((state_r == ST_IDLE) ||
                   ((state_r == ST_VBLANK) && (bcnt_r == VB_LAST)))) begin
      start_s = 1'b1;
    end else begin
      start_s = 1'b0;
    end
  end

  // Frame sequencer; output registers present the state one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      x_r           <= '0;
      y_r           <= '0;
      bcnt_r        <= 16'd0;
      pat_r         <= 2'd0;
      frame_count_r <= 16'd0;
      valid_r       <= 1'b0;
      sof_r         <= 1'b0;
      eol_r         <= 1'b0;
      pixel_r       <= 8'h00;
      busy_r        <= 1'b0;
`ifdef CAM_SRC_PRBS_EN
      lfsr_r        <= 8'h01;
`endif
    end else begin
      busy_r <= (state_r != ST_IDLE);
      if (state_r == ST_ACTIVE) begin
        valid_r <= 1'b1;
        sof_r   <= (x_r == '0) && (y_r == '0);
        eol_r   <= (x_r == X_LAST);
        pixel_r <= pixel_s;
      end else begin
        valid_r <= 1'b0;
        sof_r   <= 1'b0;
        eol_r   <= 1'b0;
        pixel_r <= 8'h00;
      end

      if (start_s) begin
        state_r       <= ST_ACTIVE;
        x_r           <= '0;
        y_r           <= '0;
        bcnt_r        <= 16'd0;
        pat_r         <= pattern_sel;
        frame_count_r <= frame_count_r + 16'd1;
`ifdef CAM_SRC_PRBS_EN
        lfsr_r        <= 8'h01;
`endif
      end else begin
        case (state_r)
          ST_IDLE: state_r <= ST_IDLE;
          ST_ACTIVE: begin
`ifdef CAM_SRC_PRBS_EN
            lfsr_r <= lfsr_next(lfsr_r);
`endif
            if (x_r == X_LAST) begin
              x_r    <= '0;
              bcnt_r <= 16'd0;
              if (y_r == Y_LAST) begin
                state_r <= ST_VBLANK;
              end else if (HB_NONE) begin
                y_r <= y_r + Y_ONE;
              end else begin
                state_r <= ST_HBLANK;
              end
            end else begin
              x_r <= x_r + X_ONE;
            end
          end
          ST_HBLANK: begin
            if (bcnt_r == HB_LAST) begin
              state_r <= ST_ACTIVE;
              y_r     <= y_r + Y_ONE;
            end else begin
              bcnt_r <= bcnt_r + 16'd1;
            end
          end
          ST_VBLANK: begin
            if (bcnt_r == VB_LAST) begin
              state_r <= ST_IDLE;
            end else begin
              bcnt_r <= bcnt_r + 16'd1;
            end
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign cam_valid   = valid_r;
  assign cam_sof     = sof_r;
  assign cam_eol     = eol_r;
  assign cam_pixel   = pixel_r;
  assign frame_count = frame_count_r;
  assign busy        = busy_r;

endmodule
